nios2_pixel_reader_master: RTL and testbench

// - Avalon-MM read master; streams a block of 32-bit words out of the on-chip memory slave to the VGA pixel path.
// - Issues pipelined word reads from base_addr and buffers read data in an internal FIFO.
// - Presents the data as a valid/ready stream with start-of-block and end-of-block markers.
// - Sits between the Nios II on-chip memory slave port (s2) and the VGA scan-out logic.

---
 rtl/nios2_reader_pkg.sv | 14 +
 rtl/nios2_pixel_reader_master_if.sv | 32 +++
 rtl/nios2_reader_fifo.sv | 47 ++++
 rtl/nios2_pixel_reader_master.sv | 123 ++++++++++++
 tb/tb_nios2_pixel_reader_master.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/nios2_reader_pkg.sv
// Shared widths, FIFO depth and FSM encoding for the pixel reader master.
package nios2_reader_pkg;
    localparam int DEF_ADDR_W     = 12;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_CNT_W      = 13;
    localparam int DEF_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;
endpackage

// File: rtl/nios2_pixel_reader_master_if.sv
// Avalon-MM read bus plus the outgoing pixel stream; master = reader, slave = memory/scan-out side.
interface nios2_pixel_reader_master_if
    import nios2_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_sop;
    logic              st_eop;

    modport master (
        output avm_address, avm_read,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output st_data, st_valid, st_sop, st_eop,
        input  st_ready
    );

    modport slave (
        input  avm_address, avm_read,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  st_data, st_valid, st_sop, st_eop,
        output st_ready
    );
endinterface

// File: rtl/nios2_reader_fifo.sv
// Show-ahead read-data FIFO: rd_data is always the head entry, no read latency.
module nios2_reader_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              do_wr, do_rd;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign rd_data = mem[rd_ptr];
    assign do_rd   = rd_en && !empty;
    // A write into a full FIFO is only allowed when the head leaves in the same cycle.
    assign do_wr   = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/nios2_pixel_reader_master.sv
// Avalon-MM block read master streaming on-chip memory words to the VGA path.
// Define PIXEL_READER_UNDERFLOW_CNT_EN to add the saturating underflow_cnt output.
module nios2_pixel_reader_master
    import nios2_reader_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
`ifdef PIXEL_READER_UNDERFLOW_CNT_EN
    output logic [15:0]       underflow_cnt,
`endif
    nios2_pixel_reader_master_if.master bus
);
    localparam int OST_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  issue_rem_q, deliver_rem_q, total_q;
    logic [OST_W-1:0]  outstanding_q;
    logic [OST_W-1:0]  fifo_count;
    logic [OST_W:0]    credit_used;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full, fifo_empty;
    logic              start_acc, active, credit_ok;
    logic              req_acc, rsp_acc, st_valid, st_acc;

    assign start_acc   = (state_q == IDLE) && start;
    assign active      = (state_q == ISSUE) || (state_q == DRAIN);
    assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    // Reserve a FIFO slot for every read in flight so returning data can never overflow.
    assign credit_ok   = !fifo_full && (credit_used < (OST_W+1)'(FIFO_DEPTH));
    assign req_acc     = bus.avm_read && !bus.avm_waitrequest;
    // Data with nothing outstanding (e.g. left over from before a reset) is dropped.
    assign rsp_acc     = bus.avm_readdatavalid && active && (outstanding_q != '0);
    assign st_valid    = !fifo_empty;
    assign st_acc      = st_valid && bus.st_ready;

    assign bus.avm_address = addr_q;
    assign bus.st_valid    = st_valid;
    assign bus.st_data     = st_valid ? fifo_head : '0;
    assign bus.st_sop      = st_valid && (deliver_rem_q == total_q);
    assign bus.st_eop      = st_valid && (deliver_rem_q == CNT_W'(1));

    nios2_reader_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (rsp_acc),
        .wr_data (bus.avm_readdata),
        .rd_en   (st_acc),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        busy         = active;
        done         = (state_q == DONE);
        bus.avm_read = (state_q == ISSUE) && (issue_rem_q != '0) && credit_ok;
        unique case (state_q)
            IDLE:    if (start) state_d = (word_count == '0) ? DONE : ISSUE;
            ISSUE:   if (req_acc && issue_rem_q == CNT_W'(1)) state_d = DRAIN;
            DRAIN:   if (st_acc && deliver_rem_q == CNT_W'(1) && outstanding_q == '0
                         && fifo_count == OST_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            issue_rem_q   <= '0;
            deliver_rem_q <= '0;
            total_q       <= '0;
            outstanding_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                addr_q        <= base_addr;
                issue_rem_q   <= word_count;
                deliver_rem_q <= word_count;
                total_q       <= word_count;
            end else begin
                if (req_acc) begin
                    addr_q      <= addr_q + 1'b1;
                    issue_rem_q <= issue_rem_q - 1'b1;
                end
                if (st_acc) deliver_rem_q <= deliver_rem_q - 1'b1;
            end
            case ({req_acc, rsp_acc})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: ;
            endcase
        end
    end

`ifdef PIXEL_READER_UNDERFLOW_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            underflow_cnt <= '0;
        else if (start_acc)
            underflow_cnt <= '0;
        else if (busy && !st_valid && bus.st_ready && underflow_cnt != 16'hFFFF)
            underflow_cnt <= underflow_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_nios2_pixel_reader_master.sv
// Directed table-driven bench for nios2_pixel_reader_master with a 1-cycle-latency memory model.
module tb_nios2_pixel_reader_master;
    typedef struct {
        logic [11:0] base;
        logic [12:0] count;
        bit          rand_wait;
        int          hold;
        int          exp_peak;
        bit          full_rate;
        bit          restart;
        logic [11:0] exp_last;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] word_count;
    logic        busy, done;
`ifdef PIXEL_READER_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt;
`endif

    nios2_pixel_reader_master_if bus ();

    nios2_pixel_reader_master dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
`ifdef PIXEL_READER_UNDERFLOW_CNT_EN
        .underflow_cnt (underflow_cnt),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor state, written only by the posedge monitor.
    logic [11:0] req_q[$];
    logic [33:0] stream_q[$];
    int          inflight, peak, stall_viol, cyc_cnt;
    int          first_rdv, first_valid, first_st, last_st;
    bit          stalled_prev, mon_acc, mon_sacc, rsp_pend;
    logic [11:0] stall_addr, rsp_addr;
    bit          mon_clr = 1'b0;

    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return {20'hC0DE5, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        mon_acc  = bus.avm_read && !bus.avm_waitrequest;
        mon_sacc = bus.st_valid && bus.st_ready;
        rsp_pend = mon_acc;
        rsp_addr = bus.avm_address;
        cyc_cnt++;
        if (mon_clr) begin
            req_q.delete();
            stream_q.delete();
            peak = 0; inflight = 0; stall_viol = 0;
            first_rdv = -1; first_valid = -1; first_st = -1; last_st = -1;
        end
        if (!reset_n) begin
            inflight = 0;
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev && !(bus.avm_read && bus.avm_address == stall_addr)) stall_viol++;
            stalled_prev = bus.avm_read && bus.avm_waitrequest;
            stall_addr   = bus.avm_address;
            if (mon_acc) req_q.push_back(bus.avm_address);
            if (mon_sacc) begin
                stream_q.push_back({bus.st_data, bus.st_sop, bus.st_eop});
                if (first_st < 0) first_st = cyc_cnt;
                last_st = cyc_cnt;
            end
            if (bus.avm_readdatavalid && first_rdv < 0) first_rdv = cyc_cnt;
            if (bus.st_valid && first_valid < 0) first_valid = cyc_cnt;
            inflight = inflight + int'(mon_acc) - int'(mon_sacc);
            if (inflight > peak) peak = inflight;
        end
    end

    // Memory slave: every accepted read returns data exactly one cycle later.
    always @(negedge clk) begin
        bus.avm_readdatavalid = rsp_pend;
        bus.avm_readdata      = rsp_pend ? mem_word(rsp_addr) : 32'h0;
    end

    task automatic run_block(input vec_t v, input string tag);
        bit          got;
        int          n;
        logic [11:0] a;
        @(negedge clk);
        mon_clr = 1'b1; base_addr = v.base; word_count = v.count; start = 1'b1;
        bus.st_ready = (v.hold == 0); bus.avm_waitrequest = 1'b0;
        @(negedge clk);
        mon_clr = 1'b0; start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            if (done) begin
                got = 1'b1;
                chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
            end else begin
                if (v.exp_peak != 0 && c == v.hold - 1) begin
                    chk({tag, "_bp_read_off"}, 64'(bus.avm_read), 64'(0));
                    chk({tag, "_bp_inflight"}, 64'(inflight), 64'(v.exp_peak));
                    chk({tag, "_bp_reqs"}, 64'(req_q.size()), 64'(v.exp_peak));
                end
                if (c == v.hold) bus.st_ready = 1'b1;
                if (v.restart && c == 2) begin
                    start = 1'b1; base_addr = 12'hABC; word_count = 13'd5;
                end else start = 1'b0;
                bus.avm_waitrequest = v.rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=no_done expected=done", tag);
        end
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 64'(done), 64'(0));
        bus.avm_waitrequest = 1'b0; bus.st_ready = 1'b1;
        n = int'(v.count);
        chk({tag, "_words"}, 64'(stream_q.size()), 64'(n));
        chk({tag, "_reqs"}, 64'(req_q.size()), 64'(n));
        for (int i = 0; i < n && i < stream_q.size() && i < req_q.size(); i++) begin
            a = v.base + 12'(i);
            chk($sformatf("%s_addr%0d", tag, i), 64'(req_q[i]), 64'(a));
            chk($sformatf("%s_word%0d", tag, i), 64'(stream_q[i]),
                64'({mem_word(a), i == 0, i == n - 1}));
        end
        if (req_q.size() == n && n > 0)
            chk({tag, "_last_addr"}, 64'(req_q[n-1]), 64'(v.exp_last));
        chk({tag, "_stall_hold"}, 64'(stall_viol), 64'(0));
        if (v.exp_peak != 0) chk({tag, "_peak"}, 64'(peak), 64'(v.exp_peak));
        else                 chk({tag, "_peak_le16"}, 64'(peak <= 16), 64'(1));
        chk({tag, "_latency"}, 64'(first_valid - first_rdv), 64'(1));
        if (v.full_rate) chk({tag, "_full_rate"}, 64'(last_st - first_st), 64'(n - 1));
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{12'h010,  13'd8, 1'b0,  0,  0, 1'b1, 1'b0, 12'h017};
        vecs[1] = '{12'h200, 13'd40, 1'b0, 50, 16, 1'b0, 1'b0, 12'h227};
        vecs[2] = '{12'hFFE,  13'd4, 1'b0,  0,  0, 1'b1, 1'b0, 12'h001};
        vecs[3] = '{12'h345, 13'd25, 1'b1,  0,  0, 1'b0, 1'b1, 12'h35D};
        vecs[4] = '{12'h7FF,  13'd1, 1'b0,  0,  0, 1'b1, 1'b0, 12'h7FF};
        vecs[5] = '{12'hFF0, 13'd20, 1'b1, 40,  0, 1'b0, 1'b0, 12'h003};

        reset_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        bus.avm_waitrequest = 1'b0; bus.st_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_read", 64'(bus.avm_read), 64'(0));
        chk("rst_addr", 64'(bus.avm_address), 64'(0));
        chk("rst_valid", 64'(bus.st_valid), 64'(0));
        chk("rst_data", 64'(bus.st_data), 64'(0));
        chk("rst_sop_eop", 64'({bus.st_sop, bus.st_eop}), 64'(0));
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_block(vecs[i], $sformatf("v%0d", i));
`ifdef PIXEL_READER_UNDERFLOW_CNT_EN
            // Two empty cycles precede the first word at full rate.
            if (i == 0) chk("underflow_basic", 64'(underflow_cnt), 64'(2));
`endif
        end

        // Zero-length block: done one cycle after start, no bus traffic.
        @(negedge clk);
        mon_clr = 1'b1; base_addr = 12'h123; word_count = 13'd0; start = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0; start = 1'b0;
        chk("zero_done", 64'(done), 64'(1));
        chk("zero_busy", 64'(busy), 64'(0));
        chk("zero_read", 64'(bus.avm_read), 64'(0));
        @(negedge clk);
        chk("zero_done_clr", 64'(done), 64'(0));
        chk("zero_reqs", 64'(req_q.size()), 64'(0));

        // Reset after 3 of 10 words, then a clean 2-word block.
        @(negedge clk);
        mon_clr = 1'b1; base_addr = 12'h080; word_count = 13'd10; start = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0; start = 1'b0;
        for (int c = 0; c < 200 && stream_q.size() < 3; c++) @(negedge clk);
        chk("mid_words_before_rst", 64'(stream_q.size()), 64'(3));
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_read", 64'(bus.avm_read), 64'(0));
        chk("mid_rst_valid", 64'(bus.st_valid), 64'(0));
        chk("mid_rst_addr", 64'(bus.avm_address), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run_block('{12'h100, 13'd2, 1'b0, 0, 0, 1'b1, 1'b0, 12'h101}, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
